// File: rtl/bist_mem_ctrl_param_if.sv
// SRAM-side bus of the BIST controller: the muxed command/data toward the array and its read data back.
interface bist_mem_ctrl_param_if #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs_n;
  logic              mem_we_n;

  modport master (output mem_din, mem_addr, mem_cs_n, mem_we_n, input mem_dout);
  modport slave  (input mem_din, mem_addr, mem_cs_n, mem_we_n, output mem_dout);
endinterface

// File: rtl/bist_mem_ctrl_param.sv
// Memory BIST controller (checkerboard / March C-) with a functional/test mux
// in front of a single-port synchronous SRAM.
module bist_mem_ctrl_param #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tester,
  input  logic                  start,
  input  logic                  alg_sel,
  input  logic [DATA_W-1:0]     normal_inputs_data,
  input  logic [ADDR_W-1:0]     normal_inputs_addr,
  input  logic                  normal_inputs_cs,
  input  logic                  normal_inputs_we,
  bist_mem_ctrl_param_if.master mem,
  output logic                  test_done,
  output logic                  pass_or_fail,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [CNT_W-1:0]      fail_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              alg_q;
  logic [2:0]        elem_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ph_q;
  logic              fin_q;
  logic              bist_cs_n, bist_we_n;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_din;
  logic              chk_vld_q;
  logic [DATA_W-1:0] chk_exp_q;
  logic [ADDR_W-1:0] chk_addr_q;

  logic              start_run, issue;
  logic              cur_alg, cur_ph, down, pair, op_wr, op_fin, nxt_ph;
  logic [2:0]        cur_elem, last_elem, nxt_elem;
  logic [ADDR_W-1:0] cur_addr, end_addr, nxt_addr;
  logic [DATA_W-1:0] cb_base, cb, op_data;

  // Test pins own the array only while tester is high.
  assign mem.mem_din  = tester ? bist_din  : normal_inputs_data;
  assign mem.mem_addr = tester ? bist_addr : normal_inputs_addr;
  assign mem.mem_cs_n = tester ? bist_cs_n : normal_inputs_cs;
  assign mem.mem_we_n = tester ? bist_we_n : normal_inputs_we;

  assign start_run = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && tester;
  assign issue     = start_run || ((state_q == S_RUN) && tester && !fin_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start && tester) state_d = S_RUN;
      S_RUN:          if (!tester) state_d = S_IDLE; else if (fin_q) state_d = S_DRAIN;
      S_DRAIN:        state_d = tester ? S_DONE : S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Decode the op at the sequence pointer (reset to op 0 on a new start) and its successor.
  always_comb begin
    for (int i = 0; i < DATA_W; i++) cb_base[i] = i[0];
    cur_alg   = start_run ? alg_sel : alg_q;
    cur_elem  = start_run ? 3'd0    : elem_q;
    cur_addr  = start_run ? '0      : addr_q;
    cur_ph    = start_run ? 1'b0    : ph_q;
    cb        = cb_base ^ {DATA_W{cur_addr[0]}};
    down      = cur_alg && ((cur_elem == 3'd3) || (cur_elem == 3'd4));
    pair      = cur_alg && (cur_elem != 3'd0) && (cur_elem != 3'd5);
    last_elem = cur_alg ? 3'd5 : 3'd3;
    end_addr  = down ? '0 : {ADDR_W{1'b1}};
    op_wr     = 1'b0;
    op_data   = '0;
    if (!cur_alg) begin
      op_wr   = !cur_elem[0];
      op_data = cur_elem[1] ? ~cb : cb;
    end else begin
      case (cur_elem)
        3'd0:       begin op_wr = 1'b1;   op_data = '0; end
        3'd1, 3'd3: begin op_wr = cur_ph; op_data = cur_ph ? {DATA_W{1'b1}} : '0; end
        3'd2, 3'd4: begin op_wr = cur_ph; op_data = cur_ph ? '0 : {DATA_W{1'b1}}; end
        default:    begin op_wr = 1'b0;   op_data = '0; end
      endcase
    end
    nxt_elem = cur_elem;
    nxt_addr = cur_addr;
    nxt_ph   = 1'b0;
    op_fin   = 1'b0;
    if (pair && !cur_ph) begin
      nxt_ph = 1'b1;
    end else if (cur_addr == end_addr) begin
      nxt_elem = cur_elem + 3'd1;
      op_fin   = (cur_elem == last_elem);
      nxt_addr = (cur_alg && ((cur_elem == 3'd2) || (cur_elem == 3'd3))) ? {ADDR_W{1'b1}} : '0;
    end else begin
      nxt_addr = down ? cur_addr - ADDR_W'(1) : cur_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alg_q        <= 1'b0;
      elem_q       <= '0;
      addr_q       <= '0;
      ph_q         <= 1'b0;
      fin_q        <= 1'b0;
      bist_cs_n    <= 1'b1;
      bist_we_n    <= 1'b1;
      bist_addr    <= '0;
      bist_din     <= '0;
      chk_vld_q    <= 1'b0;
      chk_exp_q    <= '0;
      chk_addr_q   <= '0;
      test_done    <= 1'b0;
      pass_or_fail <= 1'b0;
      fail_addr    <= '0;
      fail_count   <= '0;
    end else begin
      if (issue) begin
        bist_cs_n <= 1'b0;
        bist_we_n <= !op_wr;
        bist_addr <= cur_addr;
        bist_din  <= op_data;
        elem_q    <= nxt_elem;
        addr_q    <= nxt_addr;
        ph_q      <= nxt_ph;
        fin_q     <= op_fin;
      end else begin
        bist_cs_n <= 1'b1;
        bist_we_n <= 1'b1;
      end
      // Read data returns a cycle after the read is presented, so expected/addr trail by one.
      chk_vld_q  <= (state_q == S_RUN) && tester && !bist_cs_n && bist_we_n;
      chk_exp_q  <= bist_din;
      chk_addr_q <= bist_addr;
      if (state_q == S_DONE) begin
        test_done    <= 1'b1;
        pass_or_fail <= (fail_count == '0);
      end
      if (start_run) begin
        alg_q        <= alg_sel;
        test_done    <= 1'b0;
        pass_or_fail <= 1'b0;
        fail_addr    <= '0;
        fail_count   <= '0;
      end else if (chk_vld_q && (mem.mem_dout != chk_exp_q)) begin
        if (fail_count == '0)        fail_addr  <= chk_addr_q;
        if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/bist_mem_ctrl_param.md
Name: bist_mem_ctrl_param

Overview:
Parametrised successor to the checkerboard-only BIST wrapper. It is a memory BIST controller with a built-in functional/test port mux for a single-port synchronous SRAM. It runs either a checkerboard or a March C- algorithm over a generic DATA_W x 2^ADDR_W array and reports pass/fail, the first failing address and a saturating fail count. It sits between the system logic, the SRAM instance and the test pins.

Parameters:
DATA_W, 2, SRAM word width in bits (>=1)
ADDR_W, 4, SRAM address width; depth N = 2^ADDR_W
CNT_W, 8, fail_count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tester  in  1  1 = BIST owns the SRAM, 0 = functional path
start  in  1  one-cycle pulse; starts a run when tester=1
alg_sel  in  1  0 = checkerboard, 1 = March C-; sampled with start
normal_inputs_data  in  DATA_W  functional write data
normal_inputs_addr  in  ADDR_W  functional address
normal_inputs_cs  in  1  functional chip select, active low
normal_inputs_we  in  1  functional write enable, active low
mem_dout  in  DATA_W  SRAM read data
mem_din  out  DATA_W  SRAM write data
mem_addr  out  ADDR_W  SRAM address
mem_cs_n  out  1  SRAM chip select, active low
mem_we_n  out  1  SRAM write enable, active low
test_done  out  1  run complete; results valid
pass_or_fail  out  1  1 = pass; meaningful only while test_done=1
fail_addr  out  ADDR_W  address of the first miscompare
fail_count  out  CNT_W  number of miscomparing reads, saturating

Behaviour:
- Mux (combinational): tester=0 -> mem_* = normal_inputs_*. tester=1 -> mem_* = BIST registers. In IDLE/DONE the BIST drives cs_n=1, we_n=1.
- Reset values: FSM=IDLE, test_done=0, pass_or_fail=0, fail_addr=0, fail_count=0, BIST cs_n=1, we_n=1, addr=0, din=0.
- SRAM model: read data is valid on mem_dout one cycle after a cycle with cs_n=0, we_n=1. The compare uses expected data and address delayed one cycle.
- FSM states: IDLE -> RUN on start&tester. RUN -> DRAIN after the last op. DRAIN -> DONE after 1 cycle. DONE -> RUN on start&tester.
- On entering RUN: clear test_done, fail_addr and fail_count; set pass_or_fail=0; latch alg_sel.
- One memory op per RUN cycle. The first op is issued in the first RUN cycle.
- Checkerboard pattern CB(a): bit i = i[0] XOR a[0]. For DATA_W=2, even addresses get 2'b10 and odd addresses get 2'b01.
- Checkerboard sequence: four ascending passes, each 0..N-1: write CB, read CB, write ~CB, read ~CB. Total 4N ops.
- March C- sequence: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0). Total 10N ops.
  - 0 and 1 mean all-zero and all-one words.
  - An r/w pair uses two consecutive cycles at the same address.
  - Descending elements run N-1..0.
- Compare: on each valid read return, if mem_dout != expected:
  - if this is the first failure of the run, capture fail_addr;
  - fail_count = fail_count+1, saturating at 2^CNT_W-1.
- DONE: test_done=1; pass_or_fail = (fail_count==0). Results hold until the next start or reset.
- start while in RUN or DRAIN is ignored. alg_sel changes mid-run are ignored.
- tester deasserted in RUN or DRAIN: abort to IDLE next cycle, test_done stays 0, BIST outputs go idle. Partial fail_* values remain readable.
- Address counter wraps only at element boundaries; there is no wrap inside an element.
- Asynchronous reset mid-run returns all state to reset values immediately.
- Timing: with start sampled at edge 0, test_done rises after edge OPS+2. OPS is 4N for checkerboard and 10N for March C-.

Test Plan:
- Functional path: tester=0, write 2'b11 to address 3, then read address 3. mem_* outputs equal normal_inputs_* every cycle; BIST outputs stay at reset values.
- Fault-free checkerboard (DATA_W=2, ADDR_W=4): start with alg_sel=0. test_done rises after edge 66; pass_or_fail=1; fail_count=0; write data alternates 2'b10/2'b01 by address parity.
- Fault-free March C-: alg_sel=1. test_done rises after edge 162; pass_or_fail=1. The down elements issue addresses 15..0.
- Stuck-at-1 on bit0 at address 5:
  - checkerboard -> pass_or_fail=0, fail_addr=5, fail_count=1 (only the ~CB read fails);
  - March C- -> fail_addr=5, fail_count=3.
- Abort and restart: drop tester at op 20 -> IDLE, test_done=0. Re-raise tester and pulse start -> a clean full run completes.
- Saturation and reset: CNT_W=2 with all cells stuck -> fail_count holds at 3. An rst_n pulse mid-run clears all outputs asynchronously.
